// File: rtl/fifo_nic2noc_pkg.sv
// Shared NIC parameters for the NIC-to-NoC output stage.
package fifo_nic2noc_pkg;

  // Ceiling log2, used to size buffer-id fields.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  localparam int unsigned N_OF_VC           = 3;
  localparam int unsigned N_OF_VN           = 2;
  localparam int unsigned N_FIFO_OUT_BUFFER = 8;
  localparam int unsigned FLIT_WIDTH        = 32;

  localparam int unsigned N_TOT_OF_VC    = N_OF_VC * N_OF_VN;
  localparam int unsigned N_BITS_POINTER = clog2(N_FIFO_OUT_BUFFER);

endpackage

// File: rtl/fifo_nic2noc_vc_pointer_slot.sv
// One VC's binding slot: busy bit plus the output-buffer id it is bound to.
module fifo_nic2noc_vc_pointer_slot
  import fifo_nic2noc_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_POINTER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_i,
  input  logic              release_i,
  input  logic [N_BITS-1:0] id_i,
  output logic              state_o,
  output logic [N_BITS-1:0] id_o
);

  // Release is applied first, so a same-cycle grant sees the slot as free.
  // The id is intentionally left stale on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_o <= 1'b0;
      id_o    <= '0;
    end else if (grant_i && (release_i || !state_o)) begin
      state_o <= 1'b1;
      id_o    <= id_i;
    end else if (release_i) begin
      state_o <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_nic2noc.sv
// NIC-to-NoC output stage: per-VC buffer binding, credit gating, flit register.
module fifo_nic2noc
  import fifo_nic2noc_pkg::*;
#(
  parameter int unsigned N_VC   = N_TOT_OF_VC,
  parameter int unsigned N_BITS = N_BITS_POINTER,
  parameter int unsigned FLIT_W = FLIT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_VC-1:0]        credit_signal_i,
  input  logic [N_VC-1:0]        free_signal_i,
  output logic [FLIT_W-1:0]      out_link_o,
  output logic                   is_valid_o,
  input  logic [N_VC-1:0]        g_fifo_pointer_i,
  input  logic [N_VC*N_BITS-1:0] g_fifo_out_buffer_id_i,
  input  logic [N_VC-1:0]        release_pointer_i,
  output logic [N_VC-1:0]        credit_signal_o,
  output logic [N_VC*N_BITS-1:0] fifo_pointed_o,
  input  logic [FLIT_W-1:0]      in_link_i,
  input  logic                   is_valid_i,
  output logic [N_VC-1:0]        free_signal_o,
  output logic [N_VC-1:0]        fifo_pointer_state_o
);

  // One binding slot per VC.
  for (genvar v = 0; v < N_VC; v++) begin : g_slot
    fifo_nic2noc_vc_pointer_slot #(
      .N_BITS (N_BITS)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .grant_i   (g_fifo_pointer_i[v]),
      .release_i (release_pointer_i[v]),
      .id_i      (g_fifo_out_buffer_id_i[v*N_BITS +: N_BITS]),
      .state_o   (fifo_pointer_state_o[v]),
      .id_o      (fifo_pointed_o[v*N_BITS +: N_BITS])
    );
  end

  // Credits only reach the interface for bound VCs; free strobes pass straight through.
  assign credit_signal_o = credit_signal_i & fifo_pointer_state_o;
  assign free_signal_o   = free_signal_i;

  // Flit pipeline register; data holds when no valid flit arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_link_o <= '0;
      is_valid_o <= 1'b0;
    end else begin
      is_valid_o <= is_valid_i;
      if (is_valid_i) begin
        out_link_o <= in_link_i;
      end
    end
  end

endmodule

// File: tb/tb_fifo_nic2noc.sv
// Directed self-checking bench for fifo_nic2noc.
module tb_fifo_nic2noc;

  localparam int unsigned NVC = 6;
  localparam int unsigned NB  = 3;
  localparam int unsigned FW  = 32;

  logic              clk;
  logic              rst;
  logic [NVC-1:0]    credit_signal_i;
  logic [NVC-1:0]    free_signal_i;
  logic [FW-1:0]     out_link_o;
  logic              is_valid_o;
  logic [NVC-1:0]    g_fifo_pointer_i;
  logic [NVC*NB-1:0] g_fifo_out_buffer_id_i;
  logic [NVC-1:0]    release_pointer_i;
  logic [NVC-1:0]    credit_signal_o;
  logic [NVC*NB-1:0] fifo_pointed_o;
  logic [FW-1:0]     in_link_i;
  logic              is_valid_i;
  logic [NVC-1:0]    free_signal_o;
  logic [NVC-1:0]    fifo_pointer_state_o;

  int unsigned n_checks;
  int unsigned n_errors;

  fifo_nic2noc dut (
    .clk                    (clk),
    .rst                    (rst),
    .credit_signal_i        (credit_signal_i),
    .free_signal_i          (free_signal_i),
    .out_link_o             (out_link_o),
    .is_valid_o             (is_valid_o),
    .g_fifo_pointer_i       (g_fifo_pointer_i),
    .g_fifo_out_buffer_id_i (g_fifo_out_buffer_id_i),
    .release_pointer_i      (release_pointer_i),
    .credit_signal_o        (credit_signal_o),
    .fifo_pointed_o         (fifo_pointed_o),
    .in_link_i              (in_link_i),
    .is_valid_i             (is_valid_i),
    .free_signal_o          (free_signal_o),
    .fifo_pointer_state_o   (fifo_pointer_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it on mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vc_id(input logic [NVC*NB-1:0] vec, input int v);
    return 32'(vec[v*NB +: NB]);
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    credit_signal_i = '0;
    free_signal_i = '0;
    g_fifo_pointer_i = '0;
    g_fifo_out_buffer_id_i = '0;
    release_pointer_i = '0;
    in_link_i = '0;
    is_valid_i = 1'b0;

    // 1. reset
    tick();
    tick();
    check("rst_state", 32'(fifo_pointer_state_o), 32'h0);
    check("rst_pointed", 32'(fifo_pointed_o), 32'h0);
    check("rst_out_link", out_link_o, 32'h0);
    check("rst_valid", 32'(is_valid_o), 32'h0);
    check("rst_credit", 32'(credit_signal_o), 32'h0);
    rst = 1'b0;

    // 2. bind VC1 -> 3, VC3 -> 2, then VC0 -> 1
    g_fifo_pointer_i = 6'b001010;
    g_fifo_out_buffer_id_i = 18'b000000010000011001;
    tick();
    check("g1_state", 32'(fifo_pointer_state_o), 32'(6'b001010));
    check("g1_vc1_id", vc_id(fifo_pointed_o, 1), 32'd3);
    check("g1_vc3_id", vc_id(fifo_pointed_o, 3), 32'd2);
    check("g1_vc0_id", vc_id(fifo_pointed_o, 0), 32'd0);
    g_fifo_pointer_i = 6'b000001;
    tick();
    check("g2_state", 32'(fifo_pointer_state_o), 32'(6'b001011));
    check("g2_vc0_id", vc_id(fifo_pointed_o, 0), 32'd1);

    // 3. release VC0 and VC3, ids stay stale
    g_fifo_pointer_i = '0;
    release_pointer_i = 6'b001001;
    tick();
    check("rel_state", 32'(fifo_pointer_state_o), 32'(6'b000010));
    check("rel_vc1_id", vc_id(fifo_pointed_o, 1), 32'd3);
    check("rel_vc3_stale", vc_id(fifo_pointed_o, 3), 32'd2);

    // 4. grant VC0 while releasing VC1
    g_fifo_pointer_i = 6'b000001;
    release_pointer_i = 6'b000010;
    tick();
    check("gr_state", 32'(fifo_pointer_state_o), 32'(6'b000001));
    check("gr_vc0_id", vc_id(fifo_pointed_o, 0), 32'd1);

    // same-VC grant + release rebinds to the new id
    g_fifo_pointer_i = 6'b000001;
    release_pointer_i = 6'b000001;
    g_fifo_out_buffer_id_i = 18'd5;
    tick();
    check("same_state", 32'(fifo_pointer_state_o), 32'(6'b000001));
    check("same_vc0_id", vc_id(fifo_pointed_o, 0), 32'd5);

    // 5. re-grant busy VC0 is ignored; bind VC4 -> 6; release idle VC2 is a no-op
    release_pointer_i = 6'b000100;
    g_fifo_pointer_i = 6'b010001;
    g_fifo_out_buffer_id_i = 18'(18'd7 | (18'd6 << 12));
    tick();
    check("busy_state", 32'(fifo_pointer_state_o), 32'(6'b010001));
    check("busy_vc0_id", vc_id(fifo_pointed_o, 0), 32'd5);
    check("vc4_id", vc_id(fifo_pointed_o, 4), 32'd6);
    g_fifo_pointer_i = '0;
    release_pointer_i = '0;

    credit_signal_i = 6'b111111;
    #1;
    check("credit_all", 32'(credit_signal_o), 32'(6'b010001));
    credit_signal_i = 6'b101010;
    #1;
    check("credit_unbound", 32'(credit_signal_o), 32'h0);
    free_signal_i = 6'b100101;
    #1;
    check("free_pass", 32'(free_signal_o), 32'(6'b100101));
    credit_signal_i = '0;
    free_signal_i = '0;

    // 6. flit path, one-cycle latency and hold
    in_link_i = 32'hA5A5_0001;
    is_valid_i = 1'b1;
    #1;
    check("flit_pre_valid", 32'(is_valid_o), 32'h0);
    tick();
    check("flit_data", out_link_o, 32'hA5A5_0001);
    check("flit_valid", 32'(is_valid_o), 32'h1);
    in_link_i = 32'hDEAD_BEEF;
    is_valid_i = 1'b0;
    tick();
    check("flit_valid_drop", 32'(is_valid_o), 32'h0);
    check("flit_hold", out_link_o, 32'hA5A5_0001);

    // reset mid-operation drops bindings and the in-flight flit
    in_link_i = 32'h0000_1234;
    is_valid_i = 1'b1;
    rst = 1'b1;
    tick();
    check("mid_rst_state", 32'(fifo_pointer_state_o), 32'h0);
    check("mid_rst_pointed", 32'(fifo_pointed_o), 32'h0);
    check("mid_rst_out_link", out_link_o, 32'h0);
    check("mid_rst_valid", 32'(is_valid_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
